// File: rtl/modadd_pkg.sv
// Shared types for the modular add/sub arbiter slice.
package modadd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 381;

    // Never returns 0 so a pointer always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/modadd_arbiter_if.sv
// Start/operand/done bus between the arbiter and the modular adder.
interface modadd_arbiter_if
    import modadd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             add_start;
    logic             add_subtract;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_m;
    logic [WIDTH-1:0] add_result;
    logic             add_done;

    modport master (
        output add_start, add_subtract, add_a, add_b, add_m,
        input  add_result, add_done
    );

    modport slave (
        input  add_start, add_subtract, add_a, add_b, add_m,
        output add_result, add_done
    );
endinterface

// File: rtl/modadd_arbiter_rr_pick.sv
// Round-robin pick: first request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PW-1:0]      idx
);
    logic [PW:0]   s;
    logic [PW-1:0] j;

    // Scan farthest-to-nearest so the nearest hit overwrites.
    always_comb begin
        win = '0;
        idx = '0;
        s   = '0;
        j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + (PW + 1)'(k);
            if (s >= (PW + 1)'(NUM_REQ)) s = s - (PW + 1)'(NUM_REQ);
            j = s[PW-1:0];
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
                idx    = j;
            end
        end
    end
endmodule

// File: rtl/modadd_arbiter.sv
// Round-robin sharing of one modular add/sub unit, one op in flight.
// Optional WAIT watchdog: define MODADD_ARB_TIMEOUT_EN.
module modadd_arbiter
    import modadd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0]         req_m,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     busy,
    output logic                     timeout_err,
    modadd_arbiter_if.master         bus
);
    localparam int PW = clog2(NUM_REQ);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-1:0] win_q;
    logic               start_q;
    logic               sub_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .PW     (PW)
    ) u_pick (
        .req(req),
        .ptr(ptr),
        .win(win),
        .idx(idx)
    );

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_nxt = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
    assign busy    = (state != IDLE);

    assign bus.add_start    = start_q;
    assign bus.add_subtract = sub_q;
    assign bus.add_a        = a_q;
    assign bus.add_b        = b_q;
    assign bus.add_m        = m_q;

`ifdef MODADD_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       wd_hit;
    logic       to_q;

    assign wd_hit      = (wd_cnt == 8'(TIMEOUT_CYCLES));
    assign timeout_err = to_q;
`else
    logic unused_cfg;

    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ptr        <= '0;
            win_q      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            start_q    <= 1'b0;
            sub_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
`ifdef MODADD_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            start_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state   <= ISSUE;
                        gnt     <= win;
                        win_q   <= win;
                        ptr     <= ptr_nxt;
                        start_q <= 1'b1;
                        sub_q   <= |(req_sub & win);
                        a_q     <= a_sel;
                        b_q     <= b_sel;
                        m_q     <= req_m;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MODADD_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (bus.add_done) begin
                        state      <= RESP;
                        rsp_valid  <= win_q;
                        rsp_result <= bus.add_result;
                    end
`ifdef MODADD_ARB_TIMEOUT_EN
                    else if (wd_hit) begin
                        state      <= RESP;
                        to_q       <= 1'b1;
                        rsp_valid  <= win_q;
                        rsp_result <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modadd_arbiter.sv
// Scoreboard bench for modadd_arbiter with a behavioural P-384 modular adder.
// Watchdog case runs only when MODADD_ARB_TIMEOUT_EN is defined.
module tb_modadd_arbiter;
    localparam int N   = 4;
    localparam int W   = 384;
    localparam int LAT = 5;
    localparam logic [W-1:0] P384 =
        384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

    typedef struct packed {
        logic [N-1:0] v;
        logic [W-1:0] r;
    } exp_t;

    logic           clk = 1'b0;
    logic           resetn;
    logic [N-1:0]   req;
    logic [N-1:0]   req_sub;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   req_m;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           busy;
    logic           timeout_err;

    modadd_arbiter_if #(.WIDTH(W)) bus();

    modadd_arbiter #(
        .NUM_REQ       (N),
        .WIDTH         (W),
        .TIMEOUT_CYCLES(63)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_sub    (req_sub),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_m      (req_m),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy),
        .timeout_err(timeout_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ops = 0;
    int nstarts = 0;
    int spur_n = 0;
    int spur_done = 0;
    bit hang = 1'b0;

    logic [N-1:0] exp_gnt[$];
    exp_t         exp_rsp[$];

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input bit sub);
        logic [W:0] s;
        if (sub) begin
            if (a >= b) s = {1'b0, a} - {1'b0, b};
            else        s = {1'b0, a} + {1'b0, P384} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, P384}) s = s - {1'b0, P384};
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_fe();
        logic [W-1:0] x;
        for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom;
        if (x >= P384) x = x - P384;
        return x;
    endfunction

    // Behavioural adder: a + (m - b) for subtract, one conditional reduce.
    initial begin : adder_model
        logic [W-1:0] ma, mb, mm;
        logic [W:0]   s;
        bit           msub;
        bit           pend;
        int           cnt;
        pend = 1'b0;
        cnt = 0;
        bus.add_done = 1'b0;
        bus.add_result = '0;
        forever begin
            @(negedge clk);
            bus.add_done = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
            end else begin
                if (bus.add_start) begin
                    nstarts++;
                    if (!hang) begin
                        pend = 1'b1;
                        cnt = LAT;
                        ma = bus.add_a;
                        mb = bus.add_b;
                        mm = bus.add_m;
                        msub = bus.add_subtract;
                    end
                end else if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        check("hold_a", bus.add_a, ma);
                        check("hold_sub", bus.add_subtract, msub);
                        s = {1'b0, ma} + {1'b0, msub ? mm - mb : mb};
                        if (s >= {1'b0, mm}) s = s - {1'b0, mm};
                        bus.add_result = s[W-1:0];
                        bus.add_done = 1'b1;
                    end
                end
                if (spur_n != spur_done) begin
                    spur_done++;
                    bus.add_result = '1;
                    bus.add_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (gnt != '0) begin
            if (exp_gnt.size() == 0) check("gnt_unexp", gnt, 0);
            else check("gnt", gnt, exp_gnt.pop_front());
        end
        if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexp", rsp_valid, 0);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_valid", rsp_valid, e.v);
                check("rsp_result", rsp_result, e.r);
            end
        end
    end

    task automatic do_op(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit sub,
                         input logic [W-1:0] r, input bit want_rsp);
        int   n;
        exp_t e;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i] = sub;
        exp_gnt.push_back(N'(1) << i);
        if (want_rsp) begin
            e.v = N'(1) << i;
            e.r = r;
            exp_rsp.push_back(e);
        end
        ops++;
        req[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 20);
        check("gnt_lat", n, 1);
        req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_rsp.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", n < 400, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int          seen;
        int          n;
        int          w;
        exp_t        e;
        logic [W-1:0] a, b;
        bit          sb;
        resetn = 1'b0;
        req = '0;
        req_sub = '0;
        req_a = '0;
        req_b = '0;
        req_m = P384;
        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", rsp_result, 0);
        check("rst_start", bus.add_start, 0);
        check("rst_add_m", bus.add_m, 0);
        check("rst_timeout", timeout_err, 0);
        resetn = 1'b1;
        @(negedge clk);

        do_op(0, 5, 7, 1'b0, 12, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("rsp_hold", rsp_result, 12);

        do_op(1, 3, 5, 1'b1, P384 - 2, 1'b1);
        wait_idle();

        spur_n++;
        repeat (4) @(negedge clk);
        check("spur_busy", busy, 0);
        check("spur_hold", rsp_result, P384 - 2);

        do_op(2, 9, 9, 1'b0, 18, 1'b0);
        @(negedge clk);
        check("wait_busy", busy, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp", rsp_valid, 0);
        resetn = 1'b1;
        repeat (3 * LAT) @(negedge clk);
        check("post_rst_busy", busy, 0);

        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = W'(100 + k);
            req_b[k*W +: W] = W'(k);
            req_sub[k] = k[0];
        end
        for (int s = 0; s < 5; s++) begin
            w = s % N;
            exp_gnt.push_back(N'(1) << w);
            e.v = N'(1) << w;
            e.r = ref_op(W'(100 + w), W'(w), w[0]);
            exp_rsp.push_back(e);
        end
        ops += 5;
        req = '1;
        seen = 0;
        n = 0;
        while (seen < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (gnt != '0) seen++;
        end
        req = '0;
        check("fair_cnt", seen, 5);
        wait_idle();

        for (int t = 0; t < 4; t++) begin
            w = $urandom_range(0, N - 1);
            a = rand_fe();
            b = rand_fe();
            sb = 1'($urandom_range(0, 1));
            do_op(w, a, b, sb, ref_op(a, b, sb), 1'b1);
            wait_idle();
        end

`ifdef MODADD_ARB_TIMEOUT_EN
        hang = 1'b1;
        do_op(3, 1, 2, 1'b0, '0, 1'b1);
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_err", timeout_err, 1);
        wait_idle();
        hang = 1'b0;
        do_op(0, 4, 6, 1'b0, 10, 1'b1);
        wait_idle();
        check("timeout_sticky", timeout_err, 1);
`else
        check("timeout_off", timeout_err, 0);
`endif

        repeat (2) @(negedge clk);
        check("start_count", nstarts, ops);
        check("gnt_q_empty", exp_gnt.size(), 0);
        check("rsp_q_empty", exp_rsp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
